// File: rtl/axis_rr_arbiter_2_1.sv
// Packet-aware round-robin arbiter: two AXI-Stream sources onto one registered master port.
// A grant locks onto a source from its first accepted beat until its tlast beat.
module axis_rr_arbiter_2_1 #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s1_tdata,
    input  logic          s1_tvalid,
    input  logic          s1_tlast,
    output logic          s1_tready,
    input  logic [DW-1:0] s2_tdata,
    input  logic          s2_tvalid,
    input  logic          s2_tlast,
    output logic          s2_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [1:0]    grant,
    output logic [CW-1:0] s1_pkt_cnt,
    output logic [CW-1:0] s2_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;          // 0: s1 granted most recently, 1: s2
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic [CW-1:0] s1_cnt_q, s1_cnt_d;
    logic [CW-1:0] s2_cnt_q, s2_cnt_d;
    logic          out_ready;
    logic          acc1, acc2;

    assign out_ready = !m_tvalid_q || m_tready;
    assign acc1      = s1_tvalid && s1_tready;
    assign acc2      = s2_tvalid && s2_tready;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (s1_tvalid && (!s2_tvalid || last_q)) begin
                    state_d = GNT1;
                    last_d  = 1'b0;
                end else if (s2_tvalid) begin
                    state_d = GNT2;
                    last_d  = 1'b1;
                end
            end
            GNT1: if (acc1 && s1_tlast) state_d = IDLE;
            GNT2: if (acc2 && s2_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the owner sees ready; the other source is held off until the packet ends.
    always_comb begin
        s1_tready = 1'b0;
        s2_tready = 1'b0;
        grant     = 2'b00;
        case (state_q)
            GNT1: begin
                s1_tready = out_ready;
                grant     = 2'b01;
            end
            GNT2: begin
                s2_tready = out_ready;
                grant     = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        s1_cnt_d   = s1_cnt_q;
        s2_cnt_d   = s2_cnt_q;
        if (acc1) begin
            m_tdata_d  = s1_tdata;
            m_tlast_d  = s1_tlast;
            m_tvalid_d = 1'b1;
        end else if (acc2) begin
            m_tdata_d  = s2_tdata;
            m_tlast_d  = s2_tlast;
            m_tvalid_d = 1'b1;
        end else if (out_ready) begin
            m_tvalid_d = 1'b0;
        end
        if (acc1 && s1_tlast) s1_cnt_d = s1_cnt_q + CW'(1);
        if (acc2 && s2_tlast) s2_cnt_d = s2_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            s1_cnt_q   <= '0;
            s2_cnt_q   <= '0;
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_cnt_q   <= s2_cnt_d;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tlast    = m_tlast_q;
    assign s1_pkt_cnt = s1_cnt_q;
    assign s2_pkt_cnt = s2_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter_2_1.sv
// Bench for axis_rr_arbiter_2_1: packet queues drive both sources, a transaction-level
// owner/output model predicts every cycle; a CW=2 copy shares the inputs for counter wrap.
module tb_axis_rr_arbiter_2_1;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s1_tdata, s2_tdata;
    logic       s1_tvalid, s1_tlast, s2_tvalid, s2_tlast;
    logic       m_tready;

    logic        s1_tready, s2_tready, m_tvalid, m_tlast;
    logic [7:0]  m_tdata;
    logic [1:0]  grant;
    logic [15:0] s1_pkt_cnt, s2_pkt_cnt;

    logic        n_s1_tready, n_s2_tready, n_m_tvalid, n_m_tlast;
    logic [7:0]  n_m_tdata;
    logic [1:0]  n_grant;
    logic [1:0]  n_s1_pkt_cnt, n_s2_pkt_cnt;

    always #5 clk = ~clk;

    axis_rr_arbiter_2_1 #(.DW(8), .CW(16)) u_dut (
        .clk(clk), .rst(rst),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(s2_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .s1_pkt_cnt(s1_pkt_cnt), .s2_pkt_cnt(s2_pkt_cnt)
    );

    axis_rr_arbiter_2_1 #(.DW(8), .CW(2)) u_dut_n (
        .clk(clk), .rst(rst),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(n_s1_tready),
        .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(n_s2_tready),
        .m_tdata(n_m_tdata), .m_tvalid(n_m_tvalid), .m_tlast(n_m_tlast), .m_tready(m_tready),
        .grant(n_grant), .s1_pkt_cnt(n_s1_pkt_cnt), .s2_pkt_cnt(n_s2_pkt_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: owner 0/1/2, prio = most recently granted source.
    int         owner, prio, cnt1, cnt2;
    logic [7:0] e_data;
    bit         e_valid, e_last, acc1_m, acc2_m;

    // Source side: packet queues, a "presenting" flag per source, valid probability.
    beat_t q1[$], q2[$];
    bit    hold1, hold2, rand_ready;
    int    pv1, pv2, c, s1_start, s2_start;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step();
        int cur;
        bit oready;
        acc1_m = 1'b0;
        acc2_m = 1'b0;
        if (rst) begin
            owner = 0; prio = 2; cnt1 = 0; cnt2 = 0;
            e_data = 8'h00; e_valid = 1'b0; e_last = 1'b0;
            return;
        end
        cur    = owner;
        oready = !e_valid || m_tready;
        acc1_m = (cur == 1) && oready && s1_tvalid;
        acc2_m = (cur == 2) && oready && s2_tvalid;
        if (acc1_m || acc2_m) begin
            e_data  = acc1_m ? s1_tdata : s2_tdata;
            e_last  = acc1_m ? s1_tlast : s2_tlast;
            e_valid = 1'b1;
            if (e_last) begin
                if (acc1_m) cnt1++; else cnt2++;
                owner = 0;
            end
        end else if (oready) begin
            e_valid = 1'b0;
        end
        if (cur == 0) begin
            if (s1_tvalid && s2_tvalid) owner = 3 - prio;
            else if (s1_tvalid)         owner = 1;
            else if (s2_tvalid)         owner = 2;
            if (owner != 0) prio = owner;
        end
    endtask

    task automatic check_comb();
        bit oready;
        oready = !e_valid || m_tready;
        check("s1_tready",   s1_tready,   (owner == 1) && oready);
        check("s2_tready",   s2_tready,   (owner == 2) && oready);
        check("n_s1_tready", n_s1_tready, (owner == 1) && oready);
        check("n_s2_tready", n_s2_tready, (owner == 2) && oready);
    endtask

    task automatic check_regs();
        logic [1:0] eg;
        eg = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
        check("m_tdata",    m_tdata,      e_data);
        check("m_tvalid",   m_tvalid,     e_valid);
        check("m_tlast",    m_tlast,      e_last);
        check("grant",      grant,        eg);
        check("s1_pkt_cnt", s1_pkt_cnt,   cnt1 & 32'hFFFF);
        check("s2_pkt_cnt", s2_pkt_cnt,   cnt2 & 32'hFFFF);
        check("n_m_tdata",  n_m_tdata,    e_data);
        check("n_m_tvalid", n_m_tvalid,   e_valid);
        check("n_grant",    n_grant,      eg);
        check("n_s1_cnt",   n_s1_pkt_cnt, cnt1 & 3);
        check("n_s2_cnt",   n_s2_pkt_cnt, cnt2 & 3);
    endtask

    task automatic drive_sources();
        if (!hold1 && q1.size() != 0 && $urandom_range(99) < pv1) hold1 = 1'b1;
        if (!hold2 && q2.size() != 0 && $urandom_range(99) < pv2) hold2 = 1'b1;
        s1_tvalid = hold1;
        s2_tvalid = hold2;
        if (hold1) begin s1_tdata = q1[0].d; s1_tlast = q1[0].l; end
        else begin s1_tdata = 8'($urandom); s1_tlast = 1'($urandom); end
        if (hold2) begin s2_tdata = q2[0].d; s2_tlast = q2[0].l; end
        else begin s2_tdata = 8'($urandom); s2_tlast = 1'($urandom); end
        if (rand_ready) m_tready = ($urandom_range(99) < 70);
    endtask

    task automatic tick();
        #1;
        check_comb();
        @(posedge clk);
        model_step();
        #1;
        check_regs();
        if (acc1_m) begin void'(q1.pop_front()); hold1 = 1'b0; end
        if (acc2_m) begin void'(q2.pop_front()); hold2 = 1'b0; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_sources();
            tick();
        end
    endtask

    task automatic run_drain(input int max);
        int k;
        k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < max) begin
            drive_sources();
            tick();
            k++;
        end
        check("drain_in_budget", k < max, 1);
        run(3);
    endtask

    task automatic add_pkt(input int src, input int len, input logic [7:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? 8'($urandom) : base + 8'(i);
            b.l = (i == len - 1);
            if (src == 1) q1.push_back(b); else q2.push_back(b);
        end
    endtask

    initial begin
        rst = 1'b1; m_tready = 1'b1; rand_ready = 1'b0;
        s1_tdata = 8'h00; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        s2_tdata = 8'h00; s2_tvalid = 1'b0; s2_tlast = 1'b0;
        hold1 = 1'b0; hold2 = 1'b0; pv1 = 100; pv2 = 100;

        // Reset held 3 cycles with both sources valid; first grant goes to s1.
        @(posedge clk);
        model_step();
        #1;
        check_regs();
        add_pkt(1, 3, 8'h01, 1'b0);
        add_pkt(2, 3, 8'h81, 1'b0);
        run(3);
        rst = 1'b0;
        run(1);
        check("first_grant", grant, 2'b01);
        run_drain(50);

        // Single source 4-beat packet.
        s1_start = cnt1;
        add_pkt(1, 4, 8'h10, 1'b0);
        run_drain(50);
        check("single_cnt", s1_pkt_cnt, s1_start + 1);

        // Contention: 4 packets each of 3 beats from both sources.
        s1_start = cnt1;
        s2_start = cnt2;
        for (int p = 0; p < 4; p++) begin
            add_pkt(1, 3, 8'hA0, 1'b0);
            add_pkt(2, 3, 8'hB0, 1'b0);
        end
        run_drain(200);
        check("contend_cnt1", s1_pkt_cnt, s1_start + 4);
        check("contend_cnt2", s2_pkt_cnt, s2_start + 4);

        // Backpressure mid-packet.
        add_pkt(1, 6, 8'h40, 1'b0);
        run(3);
        m_tready = 1'b0;
        run(5);
        check("bp_held_valid", m_tvalid, 1);
        check("bp_s1_tready", s1_tready, 0);
        m_tready = 1'b1;
        run_drain(50);

        // Owner s2 stalls mid-packet while s1 waits.
        add_pkt(2, 5, 8'h50, 1'b0);
        add_pkt(1, 2, 8'h60, 1'b0);
        run(2);
        pv2 = 0;
        run(3);
        check("stall_grant", grant, 2'b10);
        check("stall_s1_rdy", s1_tready, 0);
        pv2 = 100;
        run_drain(50);

        // Reset during beat 2 of a 4-beat packet.
        add_pkt(1, 4, 8'h70, 1'b0);
        c = 0;
        while (q1.size() > 3 && c < 20) begin
            drive_sources();
            tick();
            c++;
        end
        check("rst_setup", c < 20, 1);
        drive_sources();
        rst = 1'b1;
        tick();
        check("rst_mid_valid", m_tvalid, 0);
        check("rst_mid_grant", grant, 2'b00);
        rst = 1'b0;
        q1.delete();
        hold1 = 1'b0;
        run(2);

        // Counter wrap: 5 packets from s1; CW=2 copy wraps to 1.
        for (int p = 0; p < 5; p++) add_pkt(1, 2, 8'h90, 1'b0);
        run_drain(100);
        check("wrap_wide", s1_pkt_cnt, 5);
        check("wrap_narrow", n_s1_pkt_cnt, 1);

        // Randomized traffic with random backpressure.
        pv1 = 60;
        pv2 = 60;
        rand_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            add_pkt(1, $urandom_range(6, 1), 8'h00, 1'b1);
            add_pkt(2, $urandom_range(6, 1), 8'h00, 1'b1);
        end
        run_drain(4000);
        rand_ready = 1'b0;
        m_tready = 1'b1;
        run(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter_2_1.md
# axis_rr_arbiter_2_1

Packet-aware round-robin arbiter for two AXI-Stream sources sharing one AXI-Stream master port. It replaces a free-running external select with an internal grant. The grant locks onto a source from its first accepted beat until its tlast beat, so packets are never interleaved. Output is a registered pipeline stage that sustains one beat per cycle under continuous m_tready.

## Interface
- DW, 8: tdata width in bits
- CW, 16: width of per-source packet counters
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s1_tdata  in  DW  source 1 data
- s1_tvalid  in  1  source 1 valid
- s1_tlast  in  1  source 1 end of packet
- s1_tready  out  1  source 1 ready
- s2_tdata / s2_tvalid / s2_tlast / s2_tready  in/in/in/out  DW/1/1/1  source 2, same meaning as s1
- m_tdata  out  DW  arbitrated data, registered
- m_tvalid  out  1  registered valid
- m_tlast  out  1  registered last
- m_tready  in  1  downstream ready
- grant  out  2  one-hot current owner ({s2,s1}); 2'b00 in IDLE
- s1_pkt_cnt, s2_pkt_cnt  out  CW  count of tlast beats accepted per source

## Operation
- The FSM has three states:
  - **IDLE**: no owner.
  - **GNT1**: s1 owns the output.
  - **GNT2**: s2 owns the output.
- Priority pointer `last` records the most recently granted source. The reset value of `last` is s2, so s1 wins the first tie.
- IDLE transitions:
  - Only s1_tvalid=1: go to GNT1.
  - Only s2_tvalid=1: go to GNT2.
  - Both valid: go to the source not equal to `last`.
  - Neither valid: stay in IDLE.
  - `last` is updated on entry to GNT1 or GNT2.
- Let out_ready = !m_tvalid || m_tready. This is combinational.
- In GNTx:
  - sx_tready = out_ready.
  - The other source's tready = 0.
  - In IDLE, both treadys = 0.
- A beat is accepted when sx_tvalid && sx_tready. On acceptance:
  - m_tdata and m_tlast are loaded from sx.
  - m_tvalid is set to 1.
- If out_ready=1 and no beat is accepted, m_tvalid is cleared to 0.
- While m_tvalid=1 && m_tready=0, m_tdata, m_tvalid and m_tlast hold unchanged.
- When an accepted beat has sx_tlast=1:
  - sx_pkt_cnt increments, wrapping modulo 2^CW.
  - The FSM returns to IDLE next cycle.
- The grant is held while the owning source deasserts tvalid mid-packet. There is no timeout and no preemption.
- grant reflects the state: GNT1 = 2'b01, GNT2 = 2'b10, IDLE = 2'b00.

## Timing
- Reset values: m_tdata=0, m_tvalid=0, m_tlast=0, s1_tready=0, s2_tready=0, grant=0, both counters=0, state IDLE, `last`=s2.
- Reset asserted mid-packet:
  - The partial packet is abandoned.
  - The output register is cleared; the beat in it is dropped.
  - The FSM returns to IDLE. Counters are not incremented.
- Latency from request to output:
  - Cycle 0: IDLE with s1_tvalid=1.
  - Cycle 1: GNT1, s1_tready=1 (when out_ready), beat accepted at the end of the cycle.
  - Cycle 2: m_tvalid=1 with that beat.
- Source-to-master data latency is 1 cycle.
- Throughput is one beat per cycle within a packet. There is exactly one IDLE bubble cycle between packets (the tlast cycle, then IDLE, then the next grant).
- Simultaneous events:
  - tlast accepted while the other source is valid: the FSM goes to IDLE, then grants the other source. This is fair round-robin.
  - Only the same source is valid after its tlast: it is regranted after one IDLE cycle.
- tready depends combinationally on m_tready. tdata, tvalid and tlast must not depend combinationally on tready, per AXI-Stream.

## Test plan
1. **Reset values.** Hold rst for 3 cycles with both sources valid -> all outputs at reset values, both treadys=0. First grant after reset is s1 (grant=01).
2. **Single source.** s1 sends a 4-beat packet 0x10..0x13, tlast on 0x13, m_tready=1 -> m_tdata shows 0x10..0x13 on consecutive cycles starting 2 cycles after s1_tvalid rises. m_tlast=1 only with 0x13. s1_pkt_cnt=1. s2_tready stays 0 throughout.
3. **Contention.** Both sources continuously send 3-beat packets (s1: 0xA*, s2: 0xB*) -> output alternates A,B,A,B packets with no interleaving inside a packet. One bubble per packet boundary. Counters are equal after 4 packets each.
4. **Backpressure.** m_tready=0 for 5 cycles mid-packet -> m_tdata/m_tlast are stable with m_tvalid=1. s1_tready=0 after the output register fills. No beat is lost or duplicated.
5. **Owner stalls.** s2 is granted; s2_tvalid drops for 3 cycles mid-packet while s1_tvalid=1 -> grant stays 10, s1_tready stays 0, and the s2 packet completes before s1 is granted.
6. **Reset mid-packet and counter wrap.** Assert rst during beat 2 of 4 -> m_tvalid=0 and grant=00 next cycle. Separately, with CW=2, send 5 packets from s1 -> s1_pkt_cnt=1.
